// File: rtl/sevenseg_word_sequencer_if.sv
// sevenseg_word_sequencer_if: host-side write/control/status bus and segment pins of the word sequencer.
interface sevenseg_word_sequencer_if #(
    parameter int AW = 3
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [6:0]    wr_data;
    logic [AW:0]   len;
    logic          loop;
    logic          start;
    logic          stop;
    logic          busy;
    logic          done;
    logic [AW-1:0] char_idx;
    logic          a, b, c, d, e, f, g;

    modport master (
        output wr_en, wr_addr, wr_data, len, loop, start, stop,
        input  busy, done, char_idx, a, b, c, d, e, f, g
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, len, loop, start, stop,
        output busy, done, char_idx, a, b, c, d, e, f, g
    );
endinterface

// File: rtl/sevenseg_word_sequencer.sv
// sevenseg_word_sequencer: plays a buffered word of raw active-low 7-segment patterns one character at a time.
module sevenseg_word_sequencer #(
    parameter int         MAX_CHARS = 8,
    parameter int         DWELL     = 12000000,
    parameter int         GAP       = 1200000,
    parameter logic [6:0] BLANK     = 7'b1111111
) (
    input logic clk,
    input logic rst,
    sevenseg_word_sequencer_if.slave bus
);
    localparam int AW = MAX_CHARS > 1 ? $clog2(MAX_CHARS) : 1;
    localparam int MX = DWELL > GAP ? DWELL : GAP;
    localparam int CW = MX > 2 ? $clog2(MX) : 1;
    localparam logic [1:0] S_IDLE = 2'd0, S_SHOW = 2'd1, S_GAP = 2'd2;

    logic [6:0]    mem [MAX_CHARS];
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] idx;
    logic [AW:0]   lat_len;
    logic          lat_loop, done_r, last, dwell_end, gap_end, ok_len, step, fin;

    assign last      = {1'b0, idx} == lat_len - 1'b1;
    assign dwell_end = cnt == CW'(DWELL - 1);
    assign gap_end   = cnt == CW'(GAP - 1);
    assign ok_len    = bus.len != '0 && bus.len <= (AW+1)'(MAX_CHARS);
    // step marks the end of one character's slot (dwell plus optional gap)
    assign step      = (state == S_SHOW && dwell_end && GAP == 0) || (state == S_GAP && gap_end);
    assign fin       = last && !lat_loop;

    always_ff @(posedge clk) begin
        if (bus.wr_en && {1'b0, bus.wr_addr} < (AW+1)'(MAX_CHARS))
            mem[bus.wr_addr] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            lat_len  <= '0;
            lat_loop <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (bus.stop) begin
                state <= S_IDLE;
                cnt   <= '0;
                idx   <= '0;
            end else if (state == S_IDLE) begin
                if (bus.start && ok_len) begin
                    state    <= S_SHOW;
                    cnt      <= '0;
                    idx      <= '0;
                    lat_len  <= bus.len;
                    lat_loop <= bus.loop;
                end
            end else if (step) begin
                cnt    <= '0;
                state  <= fin ? S_IDLE : S_SHOW;
                idx    <= last ? '0 : idx + 1'b1;
                done_r <= fin;
            end else if (state == S_SHOW && dwell_end) begin
                cnt   <= '0;
                state <= S_GAP;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.busy     = state != S_IDLE;
    assign bus.done     = done_r;
    assign bus.char_idx = idx;
    assign {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = state == S_SHOW ? mem[idx] : BLANK;
endmodule

// File: tb/tb_sevenseg_word_sequencer.sv
// tb_sevenseg_word_sequencer: directed checks of timing, looping, stop, reset and GAP=0 playback.
module tb_sevenseg_word_sequencer;
    localparam logic [6:0] BL = 7'b1111111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [6:0] mem_exp [3];

    always #5 clk = ~clk;

    sevenseg_word_sequencer_if #(.AW(3)) b0 ();
    sevenseg_word_sequencer_if #(.AW(3)) b1 ();

    sevenseg_word_sequencer #(.MAX_CHARS(8), .DWELL(4), .GAP(2), .BLANK(BL)) dut0 (
        .clk(clk), .rst(rst), .bus(b0.slave)
    );
    sevenseg_word_sequencer #(.MAX_CHARS(8), .DWELL(4), .GAP(0), .BLANK(BL)) dut1 (
        .clk(clk), .rst(rst), .bus(b1.slave)
    );

    wire [6:0] seg0 = {b0.a, b0.b, b0.c, b0.d, b0.e, b0.f, b0.g};
    wire [6:0] seg1 = {b1.a, b1.b, b1.c, b1.d, b1.e, b1.f, b1.g};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // position i within a 6-cycle-per-character run of n characters
    task automatic expect_pos(input int i, input int n);
        int p;
        p = i % (6 * n);
        chk($sformatf("seg@%0d", i), 32'(seg0), 32'((p % 6) < 4 ? mem_exp[p / 6] : BL));
        chk($sformatf("busy@%0d", i), 32'(b0.busy), 32'd1);
        chk($sformatf("idx@%0d", i), 32'(b0.char_idx), 32'(p / 6));
        chk($sformatf("done@%0d", i), 32'(b0.done), 32'd0);
    endtask

    task automatic start0(input int n, input logic lp);
        b0.len = 4'(n); b0.loop = lp; b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
    endtask

    task automatic idle0(input string tag, input logic dn);
        chk({tag, "_busy"}, 32'(b0.busy), 32'd0);
        chk({tag, "_done"}, 32'(b0.done), 32'(dn));
        chk({tag, "_idx"}, 32'(b0.char_idx), 32'd0);
        chk({tag, "_seg"}, 32'(seg0), 32'(BL));
    endtask

    initial begin
        mem_exp[0] = 7'h01; mem_exp[1] = 7'h4F; mem_exp[2] = 7'h12;
        {b0.wr_en, b0.wr_addr, b0.wr_data, b0.len, b0.loop, b0.start, b0.stop} = '0;
        {b1.wr_en, b1.wr_addr, b1.wr_data, b1.len, b1.loop, b1.start, b1.stop} = '0;
        tick(); tick();
        rst = 1'b0;
        idle0("reset", 1'b0);
        chk("reset_seg1", 32'(seg1), 32'(BL));
        for (int i = 0; i < 3; i++) begin
            b0.wr_en = 1'b1; b0.wr_addr = 3'(i); b0.wr_data = mem_exp[i];
            b1.wr_en = 1'b1; b1.wr_addr = 3'(i); b1.wr_data = mem_exp[i];
            tick();
        end
        b0.wr_en = 1'b0; b1.wr_en = 1'b0;
        // one-shot pass
        start0(3, 1'b0);
        for (int i = 0; i < 18; i++) begin
            expect_pos(i, 3);
            tick();
        end
        idle0("oneshot_end", 1'b1);
        tick();
        idle0("oneshot_after", 1'b0);
        // looping pass, then stop during h4F
        start0(3, 1'b1);
        for (int i = 0; i < 24; i++) begin
            expect_pos(i, 3);
            tick();
        end
        chk("loop_show4F", 32'(seg0), 32'h4F);
        b0.stop = 1'b1;
        tick();
        b0.stop = 1'b0;
        idle0("stopped", 1'b0);
        // invalid lengths
        start0(0, 1'b0);
        idle0("len0", 1'b0);
        start0(9, 1'b0);
        idle0("len9", 1'b0);
        // start and stop together
        b0.stop = 1'b1;
        start0(3, 1'b0);
        b0.stop = 1'b0;
        idle0("startstop", 1'b0);
        // restart mid-run ignored; live rewrite of shown character
        start0(3, 1'b0);
        for (int i = 0; i < 18; i++) begin
            expect_pos(i, 3);
            if (i == 2) begin
                b0.len = 4'd1; b0.loop = 1'b1; b0.start = 1'b1;
            end else if (i == 6) begin
                b0.wr_en = 1'b1; b0.wr_addr = 3'd1; b0.wr_data = 7'h00;
            end
            tick();
            b0.start = 1'b0; b0.wr_en = 1'b0;
            if (i == 6) mem_exp[1] = 7'h00;
        end
        idle0("restart_end", 1'b1);
        tick();
        // reset during gap of character 1
        start0(3, 1'b0);
        for (int i = 0; i <= 10; i++) begin
            expect_pos(i, 3);
            if (i < 10) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle0("midrst", 1'b0);
        start0(3, 1'b0);
        for (int i = 0; i < 18; i++) begin
            expect_pos(i, 3);
            tick();
        end
        idle0("replay_end", 1'b1);
        // GAP = 0 instance: back-to-back characters
        b1.len = 4'd2; b1.loop = 1'b0; b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("g0_seg@%0d", i), 32'(seg1), 32'(i < 4 ? 7'h01 : 7'h4F));
            chk($sformatf("g0_busy@%0d", i), 32'(b1.busy), 32'd1);
            chk($sformatf("g0_idx@%0d", i), 32'(b1.char_idx), 32'(i / 4));
            tick();
        end
        chk("g0_done", 32'(b1.done), 32'd1);
        chk("g0_busy_end", 32'(b1.busy), 32'd0);
        chk("g0_seg_end", 32'(seg1), 32'(BL));
        tick();
        chk("g0_done_after", 32'(b1.done), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sevenseg_word_sequencer.md
Name: sevenseg_word_sequencer

Overview:
- Stores a short word as raw 7-segment patterns in a small write-only buffer.
- On command, shows the characters one at a time on the single a..g display. Each character is held for a fixed dwell time, followed by a blank gap.
- Runs either one-shot or looping.
- Sits between the control logic (or a host register interface) and the board's seven-segment pins.
- Pins are active-low (0 = segment lit), so 7'b1111111 is blank.

Parameters:
- MAX_CHARS, 8: buffer depth in characters.
- DWELL, 12000000: clock cycles each character is displayed (must be at least 1).
- GAP, 1200000: clock cycles of blank display between characters (0 means no gap).
- BLANK, 7'b1111111: pattern driven when nothing is shown.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  AW=clog2(MAX_CHARS)  buffer index to write.
- wr_data  in  7  segment pattern {a,b,c,d,e,f,g}, active-low.
- len  in  AW+1  number of characters to show; sampled on an accepted start.
- loop  in  1  1 = repeat forever, 0 = one pass; sampled on an accepted start.
- start  in  1  single-cycle start request.
- stop  in  1  single-cycle abort request.
- busy  out  1  high while in SHOW or GAP.
- done  out  1  one-cycle pulse when a one-shot pass completes.
- char_idx  out  AW  index of the character currently in progress.
- a, b, c, d, e, f, g  out  1 each  segment drives, active-low.

Behaviour:
- One clock domain, clk. Everything is sampled on the rising edge; reset is synchronous and active-high.
- Reset values:
  - state = IDLE; busy = 0; done = 0; char_idx = 0.
  - Internal dwell/gap counter = 0; latched len and latched loop = 0.
  - a..g = BLANK.
  - Buffer contents are not reset.
- Segment outputs are decoded from registered state only, so they are glitch-free:
  - In SHOW, {a..g} = buf[char_idx].
  - Otherwise, {a..g} = BLANK.
- Buffer writes:
  - With wr_en = 1 and wr_addr < MAX_CHARS, buf[wr_addr] takes wr_data at the clock edge. Writes with wr_addr >= MAX_CHARS are ignored.
  - Writes are allowed in any state.
  - A write to the character currently shown appears on a..g the following cycle.
- State IDLE:
  - busy = 0 and display is blank.
  - start = 1 with 1 <= len <= MAX_CHARS is accepted: latch len and loop, set char_idx = 0, clear the counter, go to SHOW.
  - start with len = 0 or len > MAX_CHARS is ignored and the block stays in IDLE.
- State SHOW:
  - The counter increments every cycle.
  - When the counter reaches DWELL-1, clear the counter. Go to GAP if GAP > 0; otherwise apply the advance rule directly.
  - Net effect: each character is visible for exactly DWELL cycles.
- State GAP:
  - Display is blank and the counter increments.
  - When the counter reaches GAP-1, clear the counter and apply the advance rule.
- Advance rule:
  - If char_idx < latched_len-1: increment char_idx and go to SHOW.
  - Else, if latched loop = 1: char_idx = 0 and go to SHOW.
  - Else: go to IDLE, char_idx = 0, and assert done for exactly one cycle (the first IDLE cycle).
- start while busy is ignored; the len and loop inputs have no effect mid-run.
- stop = 1 in any state:
  - The next state is IDLE with char_idx = 0, counter = 0, display blank and no done pulse.
  - stop and start in the same cycle: stop wins and nothing is started.
- Reset asserted mid-operation overrides everything: the next cycle is the full reset state and the buffer contents are retained.
- Counter width is clog2(max(DWELL, GAP, 2)). The counter never wraps past its terminal count.
- Latency: start accepted at edge N; buf[0] is visible from cycle N+1 and busy = 1 from cycle N+1.

Test Plan (DWELL=4, GAP=2, MAX_CHARS=8):
- Write buf[0..2] = 7'h01, 7'h4F, 7'h12; start with len=3, loop=0.
  - Required: a..g shows h01×4, BLANK×2, h4F×4, BLANK×2, h12×4, BLANK×2.
  - Then IDLE with done high for 1 cycle; busy high for exactly 18 cycles.
- Same word with loop=1.
  - Required: after the third gap, h01 reappears; char_idx sequence is 0,1,2,0,…; done never pulses.
  - Pulse stop during h4F: the next cycle shows BLANK, busy = 0, done = 0.
- start with len=0, then with len=9.
  - Required: no state change; busy stays 0; display stays BLANK.
- Edge-case start/stop/write sequence:
  - start and stop in the same cycle from IDLE: required to remain IDLE.
  - start pulsed again mid-run: required to leave no effect on timing or char_idx.
  - Write buf[1] = 7'h00 while buf[1] is displayed: required to show 7'h00 the next cycle.
- Assert rst for 1 cycle during GAP of character 1.
  - Required: the next cycle shows all outputs at reset values.
  - A following start with len=3 replays the previously written buffer unchanged.
- Rebuild with GAP=0, len=2, loop=0.
  - Required: h01×4 then h4F×4 back-to-back, with no blank in between; then done.
